// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared core definitions: NOP encoding, fetch FSM states,
//               base opcodes and the jalr-style target alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_VALID = 3'd3,
        FETCH_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Branch/jump targets always have bit 0 forced low, as jalr does.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage: PC register, single-outstanding
//               imem request/response handshake, redirect squash and halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc_reg, pc_nx;
    logic [31:0]  inst_reg, inst_nx;
    logic         drop, drop_nx;
    logic         misalign, misalign_nx;
    logic [31:0]  target;
    logic         target_bad;

    assign target     = align_target(redirect_pc);
    assign target_bad = target[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH_IDLE;
            pc_reg   <= RESET_PC;
            inst_reg <= NOP_INST;
            drop     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_reg   <= pc_nx;
            inst_reg <= inst_nx;
            drop     <= drop_nx;
            misalign <= misalign_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_reg;
        inst_nx     = inst_reg;
        drop_nx     = drop;
        misalign_nx = misalign;

        if (state != FETCH_HALT && redirect && target_bad) begin
            // Any outstanding response is simply never looked at again.
            state_nx    = FETCH_HALT;
            misalign_nx = 1'b1;
            drop_nx     = 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (redirect) pc_nx = target;
                    state_nx = FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (redirect) begin
                        pc_nx = target;
                        // Accepted at the old address: its response must be dropped.
                        if (imem_ready) begin
                            drop_nx  = 1'b1;
                            state_nx = FETCH_WAIT;
                        end
                    end else if (imem_ready) begin
                        state_nx = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect) begin
                        pc_nx = target;
                        if (imem_rvalid) begin
                            drop_nx  = 1'b0;
                            state_nx = FETCH_REQ;
                        end else begin
                            drop_nx = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop_nx  = 1'b0;
                            state_nx = FETCH_REQ;
                        end else begin
                            inst_nx  = imem_rdata;
                            state_nx = FETCH_VALID;
                        end
                    end
                end
                FETCH_VALID: begin
                    if (redirect) begin
                        pc_nx    = target;
                        state_nx = FETCH_REQ;
                    end else if (inst_ack) begin
                        pc_nx    = pc_reg + 32'd4;
                        state_nx = FETCH_REQ;
                    end
                end
                FETCH_HALT: begin
                    state_nx = FETCH_HALT;
                end
                default: begin
                    state_nx = FETCH_HALT;
                end
            endcase
        end
    end

    assign imem_req     = (state == FETCH_REQ);
    assign imem_addr    = pc_reg;
    assign inst_valid   = (state == FETCH_VALID);
    assign inst         = inst_valid ? inst_reg : NOP_INST;
    assign pc           = pc_reg;
    assign pc_plus4     = pc_reg + 32'd4;
    assign misalign_err = misalign;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory returns addr ^ 32'hA5A5_0000; a PC-level model
// tracks the architectural fetch address and is compared every cycle.
`default_nettype none

module tb_ifetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MKEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        inst_ack = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    ifetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
        .inst_ack(inst_ack), .redirect(redirect), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory and control state
    int          lat = 1;
    int          withhold = 0;
    bit          pending = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 0;
    int          accepts = 0;
    logic [31:0] last_acc = 0;
    bit          auto_ack = 1;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = 0;

    // Architectural model
    logic [31:0] exp_pc = RPC;
    bit          exp_mis = 0;
    bit          halted = 0;
    bit          held_req = 0;
    logic [31:0] held_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        chk("pc", pc, exp_pc);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
        chk("req_and_valid_exclusive", {31'b0, imem_req & inst_valid}, 32'd0);
        if (halted) begin
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_valid", {31'b0, inst_valid}, 32'd0);
        end
        if (imem_req) chk("imem_addr", imem_addr, exp_pc);
        if (inst_valid) chk("inst", inst, exp_pc ^ MKEY);
        else            chk("inst_nop", inst, NOP);
        if (held_req) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, held_addr);
        end
    endtask

    // One clock: drive inputs for the current cycle, advance model, check next.
    task automatic tick();
        logic acc;
        inst_ack    = auto_ack ? inst_valid : 1'b0;
        redirect    = redir_req;
        redirect_pc = redir_tgt;
        redir_req   = 0;
        imem_ready  = (withhold == 0);
        if (imem_req && withhold > 0) withhold--;
        acc = imem_req && imem_ready;
        if (acc) begin
            chk("one_outstanding", {31'b0, pending}, 32'd0);
            pending   = 1;
            pend_addr = imem_addr;
            pend_cnt  = lat;
            accepts++;
            last_acc  = imem_addr;
        end
        held_req  = imem_req && !imem_ready && !redirect;
        held_addr = imem_addr;
        if (!halted && redirect) begin
            if (redirect_pc[1]) begin
                halted  = 1;
                exp_mis = 1;
            end else begin
                exp_pc = {redirect_pc[31:1], 1'b0};
            end
        end else if (!halted && inst_ack && inst_valid) begin
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
        redirect = 1'b0;
        inst_ack = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pending) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr ^ MKEY;
                pending     = 0;
            end
        end
        compare_outputs();
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!inst_valid && n < bound);
        if (!inst_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        redirect    = 1'b0;
        inst_ack    = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        pending     = 0;
        withhold    = 0;
        held_req    = 0;
        exp_pc      = RPC;
        exp_mis     = 0;
        halted      = 0;
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_pc_plus4", pc_plus4, RPC + 32'd4);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 1;
    endtask

    int          nv;
    int          vcyc[3];
    logic [31:0] vpc[3];
    logic [31:0] vinst[3];
    int          start_acc;
    int          vstart;
    bit          found;

    initial begin
        // Streaming fetch with a 1-cycle memory
        do_reset();
        lat = 1; auto_ack = 1; nv = 0;
        for (int i = 0; i < 12 && nv < 3; i++) begin
            tick();
            if (inst_valid) begin
                vcyc[nv] = cyc; vpc[nv] = pc; vinst[nv] = inst; nv++;
            end
        end
        chk("stream_count", nv, 3);
        chk("valid0_cycle", vcyc[0], 4);
        chk("valid1_cycle", vcyc[1], 7);
        chk("valid2_cycle", vcyc[2], 10);
        chk("valid0_pc", vpc[0], 32'h100);
        chk("valid1_pc", vpc[1], 32'h104);
        chk("valid2_pc", vpc[2], 32'h108);
        chk("valid1_inst", vinst[1], 32'hA5A5_0104);

        // Back-pressure and slow response
        withhold = 3; lat = 4; start_acc = accepts;
        wait_valid(30, "slow");
        chk("slow_cycle", cyc, 19);
        chk("slow_accepts", accepts - start_acc, 1);
        chk("slow_pc", pc, 32'h10C);
        lat = 1;

        // Redirect while waiting on 0x104 (reset lands mid-fetch here)
        do_reset();
        lat = 3;
        wait_valid(20, "w_first");
        chk("w_first_pc", pc, 32'h100);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (pending && pc == 32'h104) found = 1;
        end
        chk("w_found_wait", {31'b0, found}, 32'd1);
        redir_req = 1; redir_tgt = 32'h200;
        wait_valid(20, "w_redir");
        chk("w_redir_pc", pc, 32'h200);
        chk("w_redir_inst", inst, 32'hA5A5_0200);
        chk("w_redir_addr", last_acc, 32'h200);

        // Redirect in WAIT coinciding with rvalid; bit 0 of target ignored
        lat = 1; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (imem_rvalid && !inst_valid) found = 1;
        end
        chk("x_found_rvalid", {31'b0, found}, 32'd1);
        redir_req = 1; redir_tgt = 32'h281;
        wait_valid(20, "x_redir");
        chk("x_redir_pc", pc, 32'h280);

        // Redirect together with inst_ack in VALID
        vstart = cyc;
        redir_req = 1; redir_tgt = 32'h300;
        tick();
        chk("v_redir_pc", pc, 32'h300);
        wait_valid(20, "v_redir");
        chk("v_redir_latency", cyc - vstart, 3);
        chk("v_redir_addr", last_acc, 32'h300);
        chk("v_redir_inst", inst, 32'hA5A5_0300);

        // Redirect in REQ while the old address is accepted
        tick();
        chk("r_in_req", {31'b0, imem_req}, 32'd1);
        redir_req = 1; redir_tgt = 32'h401;
        wait_valid(20, "r_redir");
        chk("r_redir_pc", pc, 32'h400);
        chk("r_redir_inst", inst, 32'hA5A5_0400);

        // PC wrap-around
        redir_req = 1; redir_tgt = 32'hFFFF_FFFC;
        wait_valid(20, "wrap");
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        tick();
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned target halts until reset
        redir_req = 1; redir_tgt = 32'h302;
        tick();
        chk("mis_flag", {31'b0, misalign_err}, 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("mis_req_low", {31'b0, imem_req}, 32'd0);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
        do_reset();
        tick();
        chk("mis_cleared", {31'b0, misalign_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
